// File: rtl/desumu3.sv
// Sequential subtract/divide/pass unit: captures an operand set on start and produces q/r/err with a one-cycle done pulse.
// Division is restoring, one quotient bit per cycle MSB first; all other operations resolve in a single CALC cycle.
module desumu3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] c,
  input  logic [2:0] b,
  input  logic [1:0] sl,
  output logic [6:0] q,
  output logic [2:0] r,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;

  state_t     state_q;
  logic [6:0] c_q;
  logic [2:0] b_q;
  logic [1:0] sl_q;
  logic [3:0] rem_q;
  logic [5:0] quo_q;
  logic [2:0] cnt_q;
  logic [6:0] q_q;
  logic [2:0] r_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic       ge_d;
  logic [2:0] diff_d;
  logic [3:0] rem_d;
  logic [5:0] quo_d;

  // rem_q holds the shifted-in trial value; after a successful subtract it is
  // below b, so the low three bits of the difference are exact.
  always_comb begin
    ge_d   = rem_q >= {1'b0, b_q};
    diff_d = ge_d ? (rem_q[2:0] - b_q) : rem_q[2:0];
    rem_d  = {diff_d, c_q[5]};
    quo_d  = {quo_q[4:0], ge_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      b_q     <= '0;
      sl_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            c_q     <= c;
            b_q     <= b;
            sl_q    <= sl;
            rem_q   <= {3'b000, c[6]};
            quo_q   <= '0;
            cnt_q   <= 3'd6;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          case (sl_q)
            OP_SUB: begin
              q_q     <= c_q - {4'b0000, b_q};
              r_q     <= '0;
              err_q   <= c_q < {4'b0000, b_q};
              done_q  <= 1'b1;
              state_q <= DONE;
            end
            OP_DIV: begin
              if (b_q == 3'd0) begin
                q_q     <= 7'h7F;
                r_q     <= '0;
                err_q   <= 1'b1;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                c_q   <= c_q << 1;
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                  q_q     <= {quo_q, ge_d};
                  r_q     <= diff_d;
                  err_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
              end
            end
            OP_PASS: begin
              q_q     <= c_q;
              r_q     <= '0;
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
            default: begin
              q_q     <= '0;
              r_q     <= '0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          endcase
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
